// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame path.
//   N_PTS    : samples per frame (FFT_Processor is fixed at 16)
//   OUT_W    : width of each t lane handed to the FFT
//   SAMPLE_W : width of the signed ADC sample
//   fsm_t    : launch FSM states of the frame collector
package fft_pkg;
    localparam int N_PTS    = 16;
    localparam int OUT_W    = 16;
    localparam int SAMPLE_W = 10;

    typedef logic signed [OUT_W-1:0] fft_sample_t;
    typedef fft_sample_t fft_frame_t [N_PTS];

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY
    } fsm_t;
endpackage

// File: rtl/fft_frame_buffer.sv
// Write-indexed fill buffer of the ping-pong pair.
//   clk, rst  : clock, synchronous active-high reset
//   s_valid   : s_data is a new sample this cycle
//   s_data    : signed sample, sign-extended to OUT_W on write
//   swap      : the hold side is taking the full frame this cycle
//   frame     : fill buffer contents, lane k = slot k
//   pend      : a full frame is waiting to be swapped out
//   drop      : a sample arrived with nowhere to go this cycle
module fft_frame_buffer #(
    parameter int SAMPLE_W = fft_pkg::SAMPLE_W,
    parameter int OUT_W    = fft_pkg::OUT_W,
    parameter int N_PTS    = fft_pkg::N_PTS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    input  logic [SAMPLE_W-1:0]             s_data,
    input  logic                            swap,
    output logic [N_PTS-1:0][OUT_W-1:0]     frame,
    output logic                            pend,
    output logic                            drop
);
    localparam int IDX_W = $clog2(N_PTS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PTS - 1);

    logic [IDX_W-1:0] idx;
    logic [OUT_W-1:0] sample;
    logic             wr_en;

    assign sample = OUT_W'($signed(s_data));

    // While a full frame is pending, idx sits at 0 and the buffer is frozen.
    // The swap cycle frees it, so a sample arriving then lands in slot 0.
    assign wr_en = s_valid && (!pend || swap);
    assign drop  = s_valid && pend && !swap;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame <= '0;
            idx   <= '0;
            pend  <= 1'b0;
        end else begin
            if (wr_en) begin
                frame[idx] <= sample;
                idx        <= (idx == LAST) ? '0 : idx + 1'b1;
            end
            if (wr_en && idx == LAST)
                pend <= 1'b1;
            else if (swap)
                pend <= 1'b0;
        end
    end
endmodule

// File: rtl/fft_frame_collector.sv
// Producer end of the FFT_Processor frame interface: collects serial samples
// into 16-sample frames, presents them on t_flat and strobes new_t.
//   clk, rst    : clock, synchronous active-high reset
//   s_valid     : s_data carries a new sample
//   s_data      : signed sample
//   t_flat      : frame to the FFT, lane k = t_flat[k*OUT_W +: OUT_W]
//   new_t       : one-cycle launch strobe
//   done        : FFT finished (level or pulse)
//   busy        : frame launched, done not yet seen
//   overrun     : sticky, a sample was dropped
//   frame_count : frames launched since reset, wrapping
module fft_frame_collector #(
    parameter int SAMPLE_W = fft_pkg::SAMPLE_W,
    parameter int OUT_W    = fft_pkg::OUT_W,
    parameter int N_PTS    = fft_pkg::N_PTS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    input  logic [SAMPLE_W-1:0]       s_data,
    output logic [N_PTS*OUT_W-1:0]    t_flat,
    output logic                      new_t,
    input  logic                      done,
    output logic                      busy,
    output logic                      overrun,
    output logic [7:0]                frame_count
);
    import fft_pkg::*;

    fsm_t                        state, state_nx;
    logic [N_PTS-1:0][OUT_W-1:0] fill_frame;
    logic [N_PTS-1:0][OUT_W-1:0] hold;
    logic                        pend, drop, swap;

    fft_frame_buffer #(
        .SAMPLE_W (SAMPLE_W),
        .OUT_W    (OUT_W),
        .N_PTS    (N_PTS)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .swap    (swap),
        .frame   (fill_frame),
        .pend    (pend),
        .drop    (drop)
    );

    assign t_flat = hold;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // done is only looked at in BUSY, so a level left over from the previous
    // frame cannot retire a frame during its launch cycle.
    always_comb begin
        state_nx = state;
        swap     = 1'b0;
        new_t    = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (pend) begin
                    swap     = 1'b1;
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                new_t    = 1'b1;
                busy     = 1'b1;
                state_nx = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (done)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Hold register only changes on swap, keeping t_flat stable for the FFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold        <= '0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (swap)
                hold <= fill_frame;
            if (drop)
                overrun <= 1'b1;
            if (state == LAUNCH)
                frame_count <= frame_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_fft_frame_collector.sv
module tb_fft_frame_collector;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic [9:0]   s_data = '0;
    logic         done = 1'b0;
    logic [255:0] t_flat;
    logic         new_t, busy, overrun;
    logic [7:0]   frame_count;

    fft_frame_collector dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .t_flat      (t_flat),
        .new_t       (new_t),
        .done        (done),
        .busy        (busy),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int pulses = 0;
    int busy_cyc = 0;

    // Reference model: samples accumulate in a queue, a full frame waits
    // until the FFT side is idle, the FFT side is a simple phase counter.
    logic [15:0]  fillq[$];
    logic [255:0] full_t;
    bit           have_full;
    logic [255:0] m_t;
    int           m_ph;       // 0 idle, 1 launching, 2 computing
    bit           m_ovr;
    logic [7:0]   m_fc;
    logic [255:0] last_flat;  // last 16 samples fed by feed_rand

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] sext(input logic [9:0] d);
        return {{6{d[9]}}, d};
    endfunction

    task automatic model_step(input logic v, input logic [9:0] d, input logic dn, input logic r);
        bit sw;
        if (r) begin
            fillq.delete();
            have_full = 0;
            full_t    = '0;
            m_t       = '0;
            m_ph      = 0;
            m_ovr     = 0;
            m_fc      = '0;
            return;
        end
        sw = have_full && (m_ph == 0);
        if (v) begin
            if (have_full && !sw)
                m_ovr = 1;
            else
                fillq.push_back(sext(d));
        end
        if (sw) begin
            m_t       = full_t;
            have_full = 0;
        end
        if (fillq.size() == 16) begin
            for (int k = 0; k < 16; k++)
                full_t[k*16 +: 16] = fillq[k];
            fillq.delete();
            have_full = 1;
        end
        case (m_ph)
            0: if (sw) m_ph = 1;
            1: begin m_ph = 2; m_fc = m_fc + 8'd1; end
            default: if (dn) m_ph = 0;
        endcase
    endtask

    task automatic cyc(input logic v, input logic [9:0] d, input logic dn, input logic r);
        @(negedge clk);
        rst = r; s_valid = v; s_data = d; done = dn;
        @(posedge clk);
        model_step(v, d, dn, r);
        #1;
        chk("t_flat", t_flat, m_t);
        chk("new_t", new_t, m_ph == 1);
        chk("busy", busy, m_ph != 0);
        chk("overrun", overrun, m_ovr);
        chk("frame_count", frame_count, m_fc);
        pulses   += int'(new_t);
        busy_cyc += int'(busy);
    endtask

    task automatic idle(input int n, input logic dn);
        for (int i = 0; i < n; i++) cyc(1'b0, 10'd0, dn, 1'b0);
    endtask

    task automatic feed_rand(input int n, input logic dn);
        logic [9:0] d;
        for (int i = 0; i < n; i++) begin
            d = 10'($urandom);
            last_flat[(i % 16)*16 +: 16] = sext(d);
            cyc(1'b1, d, dn, 1'b0);
        end
    endtask

    initial begin
        logic [9:0]   f1 [16];
        logic [255:0] exp3;

        // 1: basic frame, done tied low
        cyc(1'b0, 10'd0, 1'b0, 1'b1);
        chk("reset_tflat", t_flat, 256'd0);
        chk("reset_fc", frame_count, 256'd0);
        for (int i = 0; i < 16; i++)
            f1[i] = (i < 4) ? 10'h1FF : (i >= 8 && i < 12) ? 10'h200 : 10'h000;
        pulses = 0;
        for (int i = 0; i < 16; i++) cyc(1'b1, f1[i], 1'b0, 1'b0);
        chk("t1_no_early_launch", pulses, 256'd0);
        idle(3, 1'b0);
        chk("t1_pulses", pulses, 256'd1);
        chk("t1_t0", t_flat[15:0], 256'h01FF);
        chk("t1_t8", t_flat[8*16 +: 16], 256'hFE00);
        chk("t1_busy", busy, 256'd1);
        chk("t1_fc", frame_count, 256'd1);

        // 2+3: second frame with sign-extension corners, fills while busy
        pulses = 0;
        cyc(1'b1, 10'h200, 1'b0, 1'b0);
        cyc(1'b1, 10'h1FF, 1'b0, 1'b0);
        feed_rand(14, 1'b0);
        idle(2, 1'b0);
        chk("t3_no_launch_while_busy", pulses, 256'd0);
        cyc(1'b0, 10'd0, 1'b1, 1'b0);
        chk("t3_not_yet", new_t, 256'd0);
        cyc(1'b0, 10'd0, 1'b0, 1'b0);
        chk("t3_launch_at_2", new_t, 256'd1);
        chk("t2_lane_neg", t_flat[15:0], 256'hFE00);
        chk("t2_lane_pos", t_flat[31:16], 256'h01FF);
        idle(1, 1'b0);
        chk("t3_fc", frame_count, 256'd2);

        // 4: overrun while busy with a full fill buffer
        feed_rand(16, 1'b0);
        exp3 = last_flat;
        chk("t4_no_overrun_yet", overrun, 256'd0);
        feed_rand(3, 1'b0);
        chk("t4_overrun", overrun, 256'd1);
        cyc(1'b0, 10'd0, 1'b1, 1'b0);
        cyc(1'b0, 10'd0, 1'b0, 1'b0);
        chk("t4_launch", new_t, 256'd1);
        chk("t4_frame", t_flat, exp3);
        idle(4, 1'b0);
        cyc(1'b0, 10'd0, 1'b1, 1'b0);
        idle(2, 1'b0);
        chk("t4_overrun_sticky", overrun, 256'd1);

        // 6: reset mid-frame
        feed_rand(9, 1'b0);
        cyc(1'b0, 10'd0, 1'b0, 1'b1);
        chk("t6_tflat", t_flat, 256'd0);
        chk("t6_busy", busy, 256'd0);
        chk("t6_overrun", overrun, 256'd0);
        chk("t6_fc", frame_count, 256'd0);
        pulses = 0;
        feed_rand(16, 1'b1);
        idle(3, 1'b1);
        chk("t6_pulses", pulses, 256'd1);
        chk("t6_frame", t_flat, last_flat);

        // 5: done held high, 256 frames, counter wrap
        cyc(1'b0, 10'd0, 1'b1, 1'b1);
        pulses = 0;
        busy_cyc = 0;
        feed_rand(255 * 16, 1'b1);
        idle(4, 1'b1);
        chk("t5_fc_255", frame_count, 256'd255);
        chk("t5_pulses_255", pulses, 256'd255);
        feed_rand(16, 1'b1);
        idle(4, 1'b1);
        chk("t5_fc_wrap", frame_count, 256'd0);
        chk("t5_pulses_256", pulses, 256'd256);
        chk("t5_busy_cycles", busy_cyc, 256'd512);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 99) < 60), 10'($urandom),
                ($urandom_range(0, 99) < 15), ($urandom_range(0, 999) < 5));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
